// File: rtl/cms_pix28_cmd_ctrl.sv
// Command decoder and control/status register bank for the CMS pix28 test firmware.
// Decodes {device_id, op_code, body} words, holds config/status, and supervises test runs.
module cms_pix28_cmd_ctrl #(
  parameter logic [3:0] DEVICE_ID     = 4'h1,
  parameter int         N_TESTS       = 4,
  parameter int         TIMEOUT_W     = 20,
  parameter int         RST_PULSE_LEN = 4
) (
  input  logic                 fw_axi_clk,
  input  logic                 fw_rst,
  input  logic [31:0]          cmd_data,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic [31:0]          rd_data,
  output logic                 rd_valid,
  output logic [23:0]          cfg_static_0,
  output logic [23:0]          cfg_static_1,
  output logic [23:0]          execute_cfg,
  output logic                 execute_pulse,
  input  logic [N_TESTS-1:0]   test_done,
  output logic                 fw_soft_rst,
  output logic                 fwd_valid,
  output logic [3:0]           fwd_op,
  output logic [23:0]          fwd_body,
  output logic [31:0]          status,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EXEC_WAIT, RST_PULSE} state_t;

  localparam logic [4:0]           TEST_SPAN = (5'd1 << N_TESTS) - 5'd1;
  localparam logic [3:0]           TEST_MASK = TEST_SPAN[3:0];
  localparam logic [TIMEOUT_W-1:0] WD_LAST   = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [3:0]           PULSE_INIT = 4'(RST_PULSE_LEN - 1);

  state_t               state;
  logic [TIMEOUT_W-1:0] wd;
  logic [3:0]           pulse_cnt;
  logic [1:0]           test_idx;

  logic [3:0]  dev;
  logic [3:0]  op;
  logic [23:0] body;
  logic [3:0]  tn;
  logic        accept;
  logic        rst_cmd;
  logic        tn_ok;
  logic [1:0]  tn_idx;
  logic [3:0]  done_ext;
  logic        done_hit;

  assign dev  = cmd_data[31:28];
  assign op   = cmd_data[27:24];
  assign body = cmd_data[23:0];
  assign tn   = body[15:12];

  // Commands for another device are consumed but never reach the decoder.
  assign accept  = cmd_valid && cmd_ready && (dev == DEVICE_ID);
  assign rst_cmd = accept && (op == 4'h1);
  assign tn_ok   = $onehot(tn) && ((tn & ~TEST_MASK) == 4'h0);

  assign cmd_ready   = (state != RST_PULSE);
  assign busy        = (state != IDLE);
  assign fw_soft_rst = (state == RST_PULSE);

  always_comb begin
    case (tn)
      4'b0010: tn_idx = 2'd1;
      4'b0100: tn_idx = 2'd2;
      4'b1000: tn_idx = 2'd3;
      default: tn_idx = 2'd0;
    endcase
  end

  always_comb begin
    done_ext = '0;
    done_ext[N_TESTS-1:0] = test_done;
  end

  assign done_hit = done_ext[test_idx];

  always_ff @(posedge fw_axi_clk or posedge fw_rst) begin
    if (fw_rst) begin
      state         <= IDLE;
      wd            <= '0;
      pulse_cnt     <= '0;
      test_idx      <= '0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      cfg_static_0  <= '0;
      cfg_static_1  <= '0;
      execute_cfg   <= '0;
      execute_pulse <= 1'b0;
      fwd_valid     <= 1'b0;
      fwd_op        <= '0;
      fwd_body      <= '0;
      status        <= '0;
    end else begin
      rd_valid      <= 1'b0;
      execute_pulse <= 1'b0;
      fwd_valid     <= 1'b0;
      if (rst_cmd) begin
        // Soft reset behaves identically from IDLE and as a test abort.
        cfg_static_0 <= '0;
        cfg_static_1 <= '0;
        execute_cfg  <= '0;
        status       <= 32'h0000_0001;
        pulse_cnt    <= PULSE_INIT;
        state        <= RST_PULSE;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              case (op)
                4'h2: begin
                  cfg_static_0 <= body;
                  status[1]    <= 1'b1;
                end
                4'h3: begin
                  rd_data   <= {DEVICE_ID, op, cfg_static_0};
                  rd_valid  <= 1'b1;
                  status[2] <= 1'b1;
                end
                4'h4: begin
                  cfg_static_1 <= body;
                  status[3]    <= 1'b1;
                end
                4'h5: begin
                  rd_data   <= {DEVICE_ID, op, cfg_static_1};
                  rd_valid  <= 1'b1;
                  status[4] <= 1'b1;
                end
                4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: begin
                  fwd_valid <= 1'b1;
                  fwd_op    <= op;
                  fwd_body  <= body;
                  status[{1'b0, op} - 5'd1] <= 1'b1;
                end
                4'hE: status <= '0;
                4'hF: begin
                  if (tn_ok) begin
                    execute_cfg   <= body;
                    execute_pulse <= 1'b1;
                    status[13]    <= 1'b1;
                    test_idx      <= tn_idx;
                    wd            <= '0;
                    state         <= EXEC_WAIT;
                  end else begin
                    status[31] <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
          EXEC_WAIT: begin
            wd <= wd + 1'b1;
            if (accept) begin
              case (op)
                4'h0:    ;
                4'hE:    status <= '0;
                default: status[29] <= 1'b1;
              endcase
            end
            // Done is applied after any clear and takes priority over the watchdog.
            if (done_hit) begin
              status[5'd14 + {3'b000, test_idx}] <= 1'b1;
              state <= IDLE;
            end else if (wd == WD_LAST) begin
              status[30] <= 1'b1;
              state      <= IDLE;
            end
          end
          RST_PULSE: begin
            if (pulse_cnt == 4'd0) state <= IDLE;
            else                   pulse_cnt <= pulse_cnt - 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
